// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the execution units and the register-file write arbiter.
// The master side presents valid/rd/data per requester; the slave answers with a one-hot ready.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a registered write stage
// and a busy scoreboard used by issue for reservations and RAW/WAW hazard queries.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   wb,
    input  logic                  rsv_valid_i,
    input  logic [ADDR_W-1:0]     rsv_rd_i,
    output logic                  rsv_ready_o,
    input  logic [4*ADDR_W-1:0]   query_rs_i,
    output logic [3:0]            query_busy_o,
    output logic                  rf_rd_in_o,
    output logic [ADDR_W-1:0]     rf_rd_o,
    output logic [DATA_W-1:0]     rf_rd_input_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [PTR_W-1:0]  last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    function automatic int rr_idx(input int base, input int offset);
        return (base + offset) % NUM_REQ;
    endfunction

    // Scan from the farthest candidate down to last_grant+1 so the nearest valid one wins.
    always_comb begin
        grant        = '0;
        last_grant_d = last_grant_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (wb.req_valid[rr_idx(int'(last_grant_q), k)]) begin
                grant                                 = '0;
                grant[rr_idx(int'(last_grant_q), k)]  = 1'b1;
                last_grant_d                          = PTR_W'(rr_idx(int'(last_grant_q), k));
            end
        end
    end

    assign wb.req_ready = grant;
    assign xfer         = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rd   = sel_rd   | (wb.req_rd[i*ADDR_W +: ADDR_W]   & {ADDR_W{grant[i]}});
            sel_data = sel_data | (wb.req_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
        end
    end

    // Writes to r0 are accepted on the bus but never reach the register file.
    always_comb begin
        rf_we_d   = xfer && (sel_rd != '0);
        rf_rd_d   = xfer ? sel_rd   : rf_rd_q;
        rf_data_d = xfer ? sel_data : rf_data_q;
    end

    assign rsv_ready_o = rsv_valid_i && (!busy_q[rsv_rd_i] || (rsv_rd_i == '0));

    // A set and clear of the same index cannot coincide: a busy bit refuses the reservation.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (rsv_ready_o && (rsv_rd_i != '0)) begin
            busy_d[rsv_rd_i] = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_query
            assign query_busy_o[gi] = (query_rs_i[gi*ADDR_W +: ADDR_W] != '0)
                                      && busy_q[query_rs_i[gi*ADDR_W +: ADDR_W]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PTR_W'(NUM_REQ - 1);
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_rd_in_o    = rf_we_q;
    assign rf_rd_o       = rf_rd_q;
    assign rf_rd_input_o = rf_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writebacks are queued when a grant is
// expected and compared against the register-file write port one cycle later.
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rsv_valid;
    logic [ADDR_W-1:0]   rsv_rd;
    logic                rsv_ready;
    logic [4*ADDR_W-1:0] query_rs;
    logic [3:0]          query_busy;
    logic                rf_rd_in;
    logic [ADDR_W-1:0]   rf_rd;
    logic [DATA_W-1:0]   rf_rd_input;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (wb),
        .rsv_valid_i   (rsv_valid),
        .rsv_rd_i      (rsv_rd),
        .rsv_ready_o   (rsv_ready),
        .query_rs_i    (query_rs),
        .query_busy_o  (query_busy),
        .rf_rd_in_o    (rf_rd_in),
        .rf_rd_o       (rf_rd),
        .rf_rd_input_o (rf_rd_input)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] rd,
                           input logic [DATA_W-1:0] data);
        wb.req_valid[i]                 = v;
        wb.req_rd[i*ADDR_W +: ADDR_W]   = rd;
        wb.req_data[i*DATA_W +: DATA_W] = data;
    endtask

    // Entered shortly after a rising edge with inputs applied; leaves 1 ns after the next edge.
    task automatic tick(input logic [NUM_REQ-1:0] exp_ready);
        exp_t e;
        e = '0;
        #4;
        chk("req_ready", 64'(wb.req_ready), 64'(exp_ready));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_ready[i]) begin
                e.rd   = wb.req_rd[i*ADDR_W +: ADDR_W];
                e.data = wb.req_data[i*DATA_W +: DATA_W];
                e.we   = (e.rd != '0);
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rf_rd_in", 64'(rf_rd_in), 64'(e.we));
        if (e.we) begin
            chk("rf_rd", 64'(rf_rd), 64'(e.rd));
            chk("rf_rd_input", 64'(rf_rd_input), 64'(e.data));
        end
        $display("txn t=%0t grant=%b we=%b rd=%0d data=%h", $time, exp_ready, e.we, e.rd, e.data);
    endtask

    initial begin
        rst_n        = 1'b0;
        rsv_valid    = 1'b0;
        rsv_rd       = '0;
        query_rs     = '0;
        wb.req_valid = '0;
        wb.req_rd    = '0;
        wb.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_rd_in", 64'(rf_rd_in), 64'd0);
        chk("rst_rf_rd", 64'(rf_rd), 64'd0);
        chk("rst_rf_rd_input", 64'(rf_rd_input), 64'd0);
        chk("rst_query_busy", 64'(query_busy), 64'd0);
        rst_n = 1'b1;

        // Single requester 0
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick(3'b001);
        set_req(0, 1'b0, 5'd0, 32'h0);
        tick(3'b000);

        // Continuous competition; pointer sits at 0 so requester 1 goes first
        set_req(0, 1'b1, 5'd1, 32'h1111_0001);
        set_req(1, 1'b1, 5'd2, 32'h2222_0002);
        set_req(2, 1'b1, 5'd3, 32'h3333_0003);
        tick(3'b010);
        tick(3'b100);
        tick(3'b001);
        tick(3'b010);
        tick(3'b100);
        tick(3'b001);
        wb.req_valid = '0;

        // Reserve r7 and query {7,0,8,7}
        rsv_valid = 1'b1;
        rsv_rd    = 5'd7;
        query_rs  = {5'd7, 5'd0, 5'd8, 5'd7};
        #1;
        chk("rsv_ready_r7", 64'(rsv_ready), 64'd1);
        chk("query_before_rsv", 64'(query_busy), 64'b0000);
        tick(3'b000);
        chk("query_after_rsv", 64'(query_busy), 64'b1001);
        #1;
        chk("rsv_ready_r7_again", 64'(rsv_ready), 64'd0);
        tick(3'b000);
        rsv_rd = 5'd0;
        #1;
        chk("rsv_ready_r0", 64'(rsv_ready), 64'd1);
        tick(3'b000);
        rsv_valid = 1'b0;
        chk("query_r0_unchanged", 64'(query_busy), 64'b1001);

        // Requester 1 writes r7: busy persists while the write is on the port
        set_req(1, 1'b1, 5'd7, 32'h0000_0077);
        tick(3'b010);
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("query_during_write", 64'(query_busy), 64'b1001);
        tick(3'b000);
        chk("query_after_write", 64'(query_busy), 64'b0000);

        // Requester 2 writes r0: accepted, no register-file write
        set_req(2, 1'b1, 5'd0, 32'h0000_1234);
        tick(3'b100);
        set_req(2, 1'b0, 5'd0, 32'h0);
        // Pointer now 2, so requester 0 beats requester 2
        set_req(0, 1'b1, 5'd9, 32'hA0A0_0009);
        set_req(2, 1'b1, 5'd10, 32'hC0C0_000A);
        tick(3'b001);
        wb.req_valid = '0;
        tick(3'b000);

        // Reserve r3, write r4, then reset while the write is on the port
        rsv_valid = 1'b1;
        rsv_rd    = 5'd3;
        query_rs  = {5'd3, 5'd4, 5'd3, 5'd7};
        tick(3'b000);
        rsv_valid = 1'b0;
        set_req(1, 1'b1, 5'd4, 32'h0000_0044);
        tick(3'b010);
        wb.req_valid = '0;
        chk("query_pre_reset", 64'(query_busy), 64'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_rf_rd_in", 64'(rf_rd_in), 64'd0);
        chk("reset_query_busy", 64'(query_busy), 64'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(0, 1'b1, 5'd11, 32'h0B0B_000B);
        set_req(1, 1'b1, 5'd12, 32'h0C0C_000C);
        set_req(2, 1'b1, 5'd13, 32'h0D0D_000D);
        tick(3'b001);
        wb.req_valid = '0;
        tick(3'b000);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
